// File: rtl/nonce_collector_pkg.sv
// Shared definitions for the nonce collector: default widths, derived
// width helpers, the arbitration outcome type and the channel slice macro.
`ifndef NONCE_COLLECTOR_PKG_SV
`define NONCE_COLLECTOR_PKG_SV

// Select channel k's nonce out of a flat NUM_CH*w bus.
`define NC_CH_SLICE(k, w) [(k)*(w) +: (w)]

package nonce_collector_pkg;

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_NONCE_W = 32;

  // Outcome of one arbitration cycle.
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,   // nothing acked
    ARB_PUSH = 2'd1,   // winner acked and written to the FIFO
    ARB_DROP = 2'd2    // winner acked and discarded (stop-on-first)
  } arb_e;

  // Channel index width; at least one bit.
  function automatic int unsigned ch_w_of(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // FIFO pointer width: address bits plus a wrap bit.
  function automatic int unsigned ptr_w_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/nonce_collector_if.sv
// Handshake bundle between hash-core channels, the collector and downstream.
//   ch_valid/ch_nonce/ch_ack : per-channel found-nonce request and one-hot accept
//   out_valid/out_ready      : downstream valid/ready handshake
//   nonce_out/out_ch         : head-of-FIFO nonce and its source channel
// master = channels + downstream side, slave = collector side.
interface nonce_collector_if
  import nonce_collector_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned NONCE_W = DEF_NONCE_W
);
  localparam int unsigned CH_W = ch_w_of(NUM_CH);

  logic [NUM_CH-1:0]         ch_valid;
  logic [NUM_CH*NONCE_W-1:0] ch_nonce;
  logic [NUM_CH-1:0]         ch_ack;
  logic                      out_valid;
  logic                      out_ready;
  logic [NONCE_W-1:0]        nonce_out;
  logic [CH_W-1:0]           out_ch;

  modport master (
    output ch_valid, ch_nonce, out_ready,
    input  ch_ack, out_valid, nonce_out, out_ch
  );

  modport slave (
    input  ch_valid, ch_nonce, out_ready,
    output ch_ack, out_valid, nonce_out, out_ch
  );
endinterface

// File: rtl/nonce_collector_fifo.sv
// Synchronous FIFO with flush; wrap-bit pointers distinguish full from empty.
//   clk, rst_n      : clock, async active-low reset
//   push, din       : write din when not full
//   pop             : drop head entry when not empty
//   flush           : empty the FIFO (overrides push/pop)
//   full, empty     : occupancy flags
//   head            : oldest entry (don't-care when empty)
module nonce_collector_fifo
  import nonce_collector_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = ptr_w_of(DEPTH);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer and storage update; a push into a full FIFO is ignored.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_d = rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/nonce_collector.sv
// Multi-channel nonce collector: round-robin arbiter over NUM_CH hash cores
// feeding a result FIFO, with a sticky per-job finished flag, optional
// stop-on-first discard mode and a saturating drop counter.
//   clk, reset : clock, async active-low reset
//   start      : sync job start; flushes FIFO, clears finished/drop_cnt/rr pointer
//   bus        : channel request/ack and downstream valid/ready (slave side)
//   finished   : at least one nonce accepted since start/reset
//   fifo_full  : FIFO holds FIFO_DEPTH entries
//   drop_cnt   : nonces discarded in stop-on-first mode, saturating
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned NONCE_W       = DEF_NONCE_W,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STOP_ON_FIRST = 0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  nonce_collector_if.slave bus,
  output logic             finished,
  output logic             fifo_full,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int unsigned CH_W    = ch_w_of(NUM_CH);
  localparam int unsigned ENTRY_W = NONCE_W + CH_W;

  logic [CH_W-1:0]    rr_q, rr_d;
  logic               finished_q, finished_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               found;
  logic [CH_W-1:0]    win;
  arb_e               arb;
  logic [NUM_CH-1:0]  ch_ack_c;
  logic               push, pop, empty, full;
  logic [ENTRY_W-1:0] din, head;

  // First requesting channel at or after rr_q, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && bus.ch_valid[CH_W'((32'(rr_q) + i) % NUM_CH)]) begin
        found = 1'b1;
        win   = CH_W'((32'(rr_q) + i) % NUM_CH);
      end
    end
  end

  // Grant decision; a discard still acks so the channel can move on.
  always_comb begin
    arb      = ARB_NONE;
    ch_ack_c = '0;
    if (reset && !start && found) begin
      if ((STOP_ON_FIRST != 0) && finished_q) begin
        arb = ARB_DROP;
      end else if (!full) begin
        arb = ARB_PUSH;
      end
    end
    if (arb != ARB_NONE) begin
      ch_ack_c[win] = 1'b1;
    end
  end

  assign push = (arb == ARB_PUSH);
  assign pop  = !empty && bus.out_ready;
  assign din  = {win, bus.ch_nonce `NC_CH_SLICE(32'(win), NONCE_W)};

  nonce_collector_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (start),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Job state: rr pointer, sticky finished, saturating drop count.
  always_comb begin
    rr_d       = rr_q;
    finished_d = finished_q;
    drop_d     = drop_q;
    if (start) begin
      rr_d       = '0;
      finished_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (arb != ARB_NONE) begin
        rr_d = CH_W'((32'(win) + 1) % NUM_CH);
      end
      if (push) begin
        finished_d = 1'b1;
      end
      if ((arb == ARB_DROP) && (drop_q != '1)) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      finished_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      finished_q <= finished_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.ch_ack    = ch_ack_c;
  assign bus.out_valid = !empty;
  assign bus.nonce_out = empty ? '0 : head[NONCE_W-1:0];
  assign bus.out_ch    = empty ? '0 : head[ENTRY_W-1 -: CH_W];
  assign finished      = finished_q;
  assign fifo_full     = full;
  assign drop_cnt      = drop_q;
endmodule
